hex_display_ctrl: RTL and testbench
===================================

# hex_display_ctrl

Parametrised, registered driver for a bank of seven-segment hex displays. Captures a packed hex word from the datapath through a valid/ready handshake and holds it in a shadow register. It decodes each nibble to active-low segments, with optional leading-zero blanking and per-digit blinking. It sits between the CPU register/debug outputs and the board HEX pins, and replaces fixed-width combinational display wiring.

## Interface
- NUM_DIGITS, 8: number of displays / nibbles; legal 1..16.
- BLINK_DIV, 25_000_000: clock cycles per blink half-period; legal ≥2.
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  4*NUM_DIGITS  hex word; nibble i ([4i+3:4i]) drives digit i, digit 0 is least significant.
- blank_lz  in  1  leading-zero blanking request; captured with data_in.
- blink_mask  in  NUM_DIGITS  bit i set makes digit i blink; captured with data_in.
- load_valid  in  1  upstream offers data_in/blank_lz/blink_mask.
- load_ready  out  1  block can accept a load this cycle.
- seg_out  out  7*NUM_DIGITS  segments for digit i at [7i+6:7i]; bit 0 = a … bit 6 = g; active-low (0 = lit).

## Operation
- Shadow registers: data_q (4*NUM_DIGITS), lz_q, mask_q. They load only on accept (load_valid & load_ready at a rising edge).
- FSM states:
  - INIT: ready 0. Entered on reset. Goes to IDLE after one clock.
  - IDLE: ready 1. On accept, goes to COMMIT.
  - COMMIT: ready 0. Goes to IDLE unconditionally after one clock.
- COMMIT does the following:
  - clears the blink counter to 0;
  - forces blink phase to 0 (visible), so new data is always shown immediately.
- Decode, in active-low hex: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E. Blank = 7F.
- Leading-zero blanking (lz_q=1):
  - Digit i is blanked if nibbles NUM_DIGITS-1 down to i are all zero.
  - Digit 0 is never blanked by this rule, so an all-zero word shows a single "0".
- Blink: digit i is blanked when mask_q[i]=1 and phase=1. Blank from either rule wins over decode.
- seg_out is registered and recomputed every cycle from data_q, lz_q, mask_q and phase.
- Reset values:
  - seg_out all 7F;
  - load_ready 0;
  - data_q 0, lz_q 0, mask_q 0;
  - blink counter 0, phase 0;
  - state INIT.
- Reset mid-operation: asserting reset in any state immediately forces all of the above. A load in flight is dropped; no partial update.
- load_valid while load_ready=0 is ignored; upstream must hold it.

## Timing
- Accept at edge k: shadow registers update at k; state becomes COMMIT at k.
- seg_out shows the new value after edge k+1 (one-cycle decode latency).
- load_ready returns to 1 after edge k+1, so the earliest next accept is edge k+2. Maximum throughput is one load per 2 cycles.
- Blink counter:
  - counts 0..BLINK_DIV-1 and wraps to 0;
  - phase toggles at the wrap edge;
  - seg_out reflects the toggled phase one edge later.
- After reset release: INIT for one edge, then load_ready=1.

## Configuration
- HEX_DISP_BLINK_EN defined: blink counter, phase and mask_q are built, and blink behaves as above.
- HEX_DISP_BLINK_EN undefined: no counter is built; blink_mask is ignored and phase is constant 0. COMMIT still exists and all other timing is identical.

## Test plan
- Reset, then check outputs:
  - during reset, seg_out all 7F and load_ready=0;
  - one edge after release, load_ready=1.
- Load 0x0123ABCF with blank_lz=0 and mask=0:
  - seg_out = 40,79,24,30,08,03,46,0E (digits 7..0);
  - visible one edge after accept;
  - load_ready low for exactly one cycle.
- Load 0x00000A00 with blank_lz=1: digits 7..3 = 7F, digit 2 = 08, digits 1..0 = 40. Then load 0x00000000: only digit 0 = 40.
- Back-to-back loads with load_valid held high: accepts occur every other cycle, and the second value appears 2 cycles after the first.
- With BLINK_DIV=4, HEX_DISP_BLINK_EN defined and mask=0x01:
  - digit 0 alternates visible/7F every 4 cycles and other digits stay lit;
  - a reload mid-blank restores visibility at accept+1.
- Assert reset in COMMIT: seg_out immediately 7F, and the value that was being loaded is never displayed.

Source files
------------

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl
//   Registered driver for a bank of seven-segment hex displays. It takes a
//   packed hex word through a valid/ready handshake and holds it in shadow
//   registers. Each nibble is decoded to active-low segments, with optional
//   leading-zero blanking and per-digit blinking.
//
// Parameters
//   NUM_DIGITS : number of displays / nibbles (1..16)
//   BLINK_DIV  : clock cycles per blink half-period (>= 2)
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   data_in    in   hex word, nibble i drives digit i (digit 0 = LSB)
//   blank_lz   in   leading-zero blanking request, captured with data_in
//   blink_mask in   per-digit blink enables, captured with data_in
//   load_valid in   upstream offers data_in/blank_lz/blink_mask
//   load_ready out  block accepts a load this cycle
//   seg_out    out  digit i segments at [7i+6:7i], bit0=a..bit6=g, 0 = lit
//   state_dbg  out  current FSM state (INIT=0, IDLE=1, COMMIT=2)
//
// Handshake: a load is accepted at a rising edge where load_valid and
//   load_ready are both 1. Upstream must hold load_valid and the payload
//   stable until that edge. load_valid while load_ready=0 is ignored.
//
// Build option: define HEX_DISP_BLINK_EN to build the blink counter, the
//   blink phase and the mask register. Without it, blink_mask is ignored and
//   every digit stays visible.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    ready_q;
  logic [4*NUM_DIGITS-1:0] data_q;
  logic                    lz_q;
  logic [7*NUM_DIGITS-1:0] seg_q;
  logic [7*NUM_DIGITS-1:0] seg_d;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    accept;

  // ready_q is only ever 1 in IDLE, so this is also the IDLE-accept condition
  assign accept = load_valid & ready_q;

  // Control FSM with registered ready and the shadow word/lz registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      ready_q <= 1'b0;
      data_q  <= '0;
      lz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        S_IDLE: begin
          if (accept) begin
            state_q <= S_COMMIT;
            ready_q <= 1'b0;
            data_q  <= data_in;
            lz_q    <= blank_lz;
          end
        end
        S_COMMIT: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_INIT;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef HEX_DISP_BLINK_EN
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  logic [CW-1:0]         cnt_q;
  logic                  phase_q;
  logic [NUM_DIGITS-1:0] mask_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      mask_q  <= '0;
    end else begin
      if (accept) begin
        mask_q <= blink_mask;
      end
      if (state_q == S_COMMIT) begin
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // During COMMIT the phase is treated as visible so that the decode computed
  // on that edge shows new data even if the old phase was in its blank half.
  assign blank_mask = mask_q & {NUM_DIGITS{phase_q && (state_q != S_COMMIT)}};
`else
  // Blinking not built: the mask input has no effect
  assign blank_mask = blink_mask & {NUM_DIGITS{1'b0}};
`endif

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Walk from the most significant digit down; zero_run stays 1 while every
  // nibble seen so far (including the current one) is zero.
  always_comb begin
    logic zero_run;
    seg_d    = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (data_q[4*i +: 4] == 4'h0);
      if ((lz_q && zero_run && (i != 0)) || blank_mask[i]) begin
        seg_d[7*i +: 7] = 7'h7F;
      end else begin
        seg_d[7*i +: 7] = hex7(data_q[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg_q <= {NUM_DIGITS{7'h7F}};
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg_out    = seg_q;
  assign load_ready = ready_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;
  localparam int ND = 8;
  localparam int W  = 7 * ND;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [4*ND-1:0] data_in = '0;
  logic          blank_lz = 1'b0;
  logic [ND-1:0] blink_mask = '0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [W-1:0]  seg_out;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [31:0]  data;
    logic         lz;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .seg_out    (seg_out),
    .state_dbg  (state_dbg)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [6:0] ref_hex7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [W-1:0] model_seg(input logic [31:0] d, input logic lz);
    logic [W-1:0] r;
    int hi;
    hi = -1;
    for (int i = 0; i < ND; i++) if (d[4*i +: 4] != 4'h0) hi = i;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      if (lz && i > hi && i != 0) r[7*i +: 7] = 7'h7F;
      else r[7*i +: 7] = ref_hex7(d[4*i +: 4]);
    end
    return r;
  endfunction

  // scoreboard compare helpers
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // driver: offers a load from a falling edge, holds it until accepted,
  // pushes the expected display and returns 1 ns after the accept edge
  task automatic do_load(input logic [31:0] d, input logic lz, input logic [ND-1:0] m,
                         input logic [W-1:0] exp, output bit ok);
    int n;
    @(negedge clock);
    data_in = d; blank_lz = lz; blink_mask = m; load_valid = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!load_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (load_ready) begin
      @(posedge clock);
      #1;
      load_valid = 1'b0;
      exp_q.push_back(exp);
      ok = 1'b1;
    end else begin
      load_valid = 1'b0;
      checks++;
      errors++;
      $display("FAIL load_timeout: load_ready stayed %b, required 1", load_ready);
    end
  endtask

  initial begin
    logic [W-1:0] prev, e, base, e2, e_a, e_b, dead;
    bit ok;

    vecs[0] = '{32'h0123ABCF, 1'b0, {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h0E}};
    vecs[1] = '{32'h00000A00, 1'b1, {{5{7'h7F}}, 7'h08, 7'h40, 7'h40}};
    vecs[2] = '{32'h00000000, 1'b1, {{7{7'h7F}}, 7'h40}};
    vecs[3] = '{32'h00000000, 1'b0, {8{7'h40}}};
    vecs[4] = '{32'h89ABCDEF, 1'b1, {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}};
    vecs[5] = '{32'h01234567, 1'b1, {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}};
    vecs[6] = '{32'h10000000, 1'b1, {7'h79, {7{7'h40}}}};
    vecs[7] = '{32'h00000005, 1'b0, {{7{7'h40}}, 7'h12}};

    // reset
    repeat (3) @(posedge clock);
    #1;
    check("reset_seg", seg_out, {ND{7'h7F}});
    check_bit("reset_ready", load_ready, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_bit("init_ready_before_edge", load_ready, 1'b0);
    @(posedge clock);
    #1;
    check_bit("ready_after_init", load_ready, 1'b1);
    check("seg_after_init", seg_out, {ND{7'h40}});

    // table-driven loads
    prev = {ND{7'h40}};
    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].data, vecs[i].lz, '0, vecs[i].exp, ok);
      if (ok) begin
        check($sformatf("vec%0d_seg_at_accept", i), seg_out, prev);
        check_bit($sformatf("vec%0d_ready_low", i), load_ready, 1'b0);
        @(posedge clock);
        #1;
        check_bit($sformatf("vec%0d_ready_back", i), load_ready, 1'b1);
        check($sformatf("vec%0d_seg", i), seg_out, exp_q.pop_front());
        prev = vecs[i].exp;
      end
    end

    // random loads, some with leading zeros
    for (int i = 0; i < 6; i++) begin
      logic [31:0] d;
      logic lz;
      d  = $urandom() >> (4 * $urandom_range(0, 7));
      lz = 1'($urandom_range(0, 1));
      do_load(d, lz, '0, model_seg(d, lz), ok);
      if (ok) begin
        @(posedge clock);
        #1;
        check($sformatf("rand%0d_seg d=%h lz=%b", i, d, lz), seg_out, exp_q.pop_front());
      end
    end

    // back-to-back loads with load_valid held high
    e_a = model_seg(32'h0000BEEF, 1'b1);
    e_b = model_seg(32'h00C0FFEE, 1'b1);
    @(negedge clock);
    data_in = 32'h0000BEEF; blank_lz = 1'b1; blink_mask = '0; load_valid = 1'b1;
    check_bit("b2b_ready_pre", load_ready, 1'b1);
    @(posedge clock);
    #1;
    exp_q.push_back(e_a);
    data_in = 32'h00C0FFEE;
    check_bit("b2b_ready_k", load_ready, 1'b0);
    @(posedge clock);
    #1;
    check_bit("b2b_ready_k1", load_ready, 1'b1);
    check("b2b_first_seg", seg_out, exp_q.pop_front());
    @(posedge clock);
    #1;
    check_bit("b2b_ready_k2", load_ready, 1'b0);
    exp_q.push_back(e_b);
    load_valid = 1'b0;
    check("b2b_seg_k2_still_first", seg_out, e_a);
    @(posedge clock);
    #1;
    check("b2b_second_seg", seg_out, exp_q.pop_front());
    check_bit("b2b_ready_k3", load_ready, 1'b1);

    // reset while in COMMIT drops the load
    dead = model_seg(32'h0000DEAD, 1'b0);
    do_load(32'h0000DEAD, 1'b0, '0, dead, ok);
    if (ok) begin
      reset = 1'b1;
      void'(exp_q.pop_front());
      #1;
      check("commit_reset_seg", seg_out, {ND{7'h7F}});
      check_bit("commit_reset_ready", load_ready, 1'b0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clock);
        #1;
        check($sformatf("post_reset_seg%0d", c), seg_out, {ND{7'h40}});
      end
      check_bit("post_reset_ready", load_ready, 1'b1);
    end

`ifdef HEX_DISP_BLINK_EN
    // blink on digit 0 with a 4-cycle half-period
    base = model_seg(32'h00000012, 1'b1);
    do_load(32'h00000012, 1'b1, 8'h01, base, ok);
    if (ok) begin
      @(posedge clock);
      #1;
      check("blink_j0", seg_out, exp_q.pop_front());
      for (int j = 1; j <= 14; j++) begin
        @(posedge clock);
        #1;
        e = base;
        if ((((j - 1) / 4) % 2) == 1) e[6:0] = 7'h7F;
        check($sformatf("blink_j%0d", j), seg_out, e);
      end
      e2 = model_seg(32'h00000034, 1'b1);
      do_load(32'h00000034, 1'b1, 8'h01, e2, ok);
      if (ok) begin
        e = base;
        e[6:0] = 7'h7F;
        check("reload_mid_blank_at_accept", seg_out, e);
        @(posedge clock);
        #1;
        check("reload_visible", seg_out, exp_q.pop_front());
        @(posedge clock);
        #1;
        check("reload_visible_next", seg_out, e2);
      end
    end
`else
    // blinking not built: the mask has no effect
    base = model_seg(32'h00000012, 1'b1);
    do_load(32'h00000012, 1'b1, 8'h01, base, ok);
    if (ok) begin
      @(posedge clock);
      #1;
      check("noblink_j0", seg_out, exp_q.pop_front());
      for (int j = 1; j <= 12; j++) begin
        @(posedge clock);
        #1;
        check($sformatf("noblink_j%0d", j), seg_out, base);
      end
    end
`endif

    check("scoreboard_empty", W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
